// File: rtl/avalon_pio_if.sv
// Avalon-MM register bus for the PIO block: 2-bit word address, 32-bit data.
// The master modport is the Nios II side; the slave modport is the PIO side.
interface avalon_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_pio.sv
// Avalon-MM parallel I/O: synchronised inputs with edge capture and level irq, plus output register.
// Optional per-bit input debounce is compiled in when PIO_DEBOUNCE_EN is defined.
module avalon_pio #(
  parameter int DATA_W          = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  avalon_pio_if.slave       bus,
  output logic              irq,
  input  logic [DATA_W-1:0] pio_in,
  output logic [DATA_W-1:0] pio_out
);

  localparam logic [1:0] ADDR_DATA_IN  = 2'd0;
  localparam logic [1:0] ADDR_DATA_OUT = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;
  localparam logic [1:0] ARM_DONE      = 2'd3;

  logic [DATA_W-1:0] sync1_q, sync1_d;
  logic [DATA_W-1:0] sync2_q, sync2_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] irq_mask_q, irq_mask_d;
  logic [DATA_W-1:0] edge_cap_q, edge_cap_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [1:0]        arm_q, arm_d;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] edge_det;
  logic [DATA_W-1:0] wr_bits;
  logic              wr_en;
  logic              rd_en;
  logic              wr_unused;

  function automatic logic [31:0] zext(input logic [DATA_W-1:0] v);
    logic [31:0] r;
    r             = '0;
    r[DATA_W-1:0] = v;
    return r;
  endfunction

  assign wr_en     = bus.chipselect & bus.write;
  assign rd_en     = bus.chipselect & bus.read;
  assign wr_bits   = bus.writedata[DATA_W-1:0];
  assign wr_unused = ^(bus.writedata >> DATA_W);

`ifdef PIO_DEBOUNCE_EN
  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0]       deb_cnt_q [DATA_W];
  logic [15:0]       deb_cnt_d [DATA_W];
  logic [DATA_W-1:0] deb_q, deb_d;

  // A bit flips only after the synced value has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < DATA_W; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      deb_q <= '0;
      for (int i = 0; i < DATA_W; i++) deb_cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < DATA_W; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign data_in = deb_q;
`else
  assign data_in = sync2_q;
`endif

  // Edges are suppressed until the synchroniser has refilled after reset, so pins
  // already high at release do not look like fresh edges.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = data_in & ~prev_q;
      1:       edge_det = ~data_in & prev_q;
      default: edge_det = data_in ^ prev_q;
    endcase
    if (arm_q != ARM_DONE) edge_det = '0;
  end

  always_comb begin
    sync1_d    = pio_in;
    sync2_d    = sync1_q;
    prev_d     = data_in;
    arm_d      = (arm_q == ARM_DONE) ? arm_q : arm_q + 2'd1;
    data_out_d = data_out_q;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA_OUT: data_out_d = wr_bits;
        ADDR_IRQ_MASK: irq_mask_d = wr_bits;
        ADDR_EDGE_CAP: edge_cap_d = edge_cap_q & ~wr_bits;
        default:       ;
      endcase
    end
    // OR-ing after the clear lets a simultaneous new edge win.
    edge_cap_d = edge_cap_d | edge_det;

    readdata_d = readdata_q;
    if (rd_en) begin
      case (bus.address)
        ADDR_DATA_IN:  readdata_d = zext(data_in);
        ADDR_DATA_OUT: readdata_d = zext(data_out_q);
        ADDR_IRQ_MASK: readdata_d = zext(irq_mask_q);
        default:       readdata_d = zext(edge_cap_q);
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      data_out_q <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
      arm_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      data_out_q <= data_out_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
      arm_q      <= arm_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign pio_out      = data_out_q;
  assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_avalon_pio.sv
// Self-checking bench for avalon_pio: directed scenarios plus a randomized run against a pin-history model.
module tb_avalon_pio;
  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  avalon_pio_if bus8();
  avalon_pio_if bus5();

  logic       irq8, irq5;
  logic [7:0] pin8, pout8;
  logic [4:0] pin5, pout5;

  int n_checks = 0;
  int n_fail   = 0;

  avalon_pio #(.DATA_W(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(clk), .RESET(rst), .bus(bus8), .irq(irq8), .pio_in(pin8), .pio_out(pout8)
  );

  avalon_pio #(.DATA_W(5), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4)) dut5 (
    .CLOCK_50(clk), .RESET(rst), .bus(bus5), .irq(irq5), .pio_in(pin5), .pio_out(pout5)
  );

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus8.chipselect = 0; bus8.read = 0; bus8.write = 0; bus8.address = 0; bus8.writedata = 0;
    bus5.chipselect = 0; bus5.read = 0; bus5.write = 0; bus5.address = 0; bus5.writedata = 0;
  endtask

  task automatic bus_write(input bit sel5, input logic [1:0] a, input logic [31:0] d);
    if (sel5) begin
      bus5.chipselect = 1; bus5.write = 1; bus5.address = a; bus5.writedata = d;
    end else begin
      bus8.chipselect = 1; bus8.write = 1; bus8.address = a; bus8.writedata = d;
    end
    tick();
    idle();
  endtask

  task automatic bus_read(input bit sel5, input logic [1:0] a, output logic [31:0] d);
    if (sel5) begin
      bus5.chipselect = 1; bus5.read = 1; bus5.address = a;
    end else begin
      bus8.chipselect = 1; bus8.read = 1; bus8.address = a;
    end
    tick();
    d = sel5 ? bus5.readdata : bus8.readdata;
    idle();
  endtask

  task automatic test_reset();
    rst = 1; pin8 = 0; pin5 = 0; idle();
    repeat (3) tick();
    n_checks++; if (bus8.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h expected %h", bus8.readdata, 32'h0); end
    n_checks++; if (pout8 !== 8'h00) begin n_fail++; $display("FAIL reset_pio_out: got %h expected %h", pout8, 8'h00); end
    n_checks++; if (irq8 !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq8); end
    n_checks++; if (pout5 !== 5'h00) begin n_fail++; $display("FAIL reset_pio_out5: got %h expected %h", pout5, 5'h00); end
    rst = 0;
    repeat (5) tick();
  endtask

  task automatic test_write_read();
    logic [31:0] d;
    bus_write(0, 2'd1, 32'h0000_00A5);
    n_checks++; if (pout8 !== 8'hA5) begin n_fail++; $display("FAIL wr_pio_out: got %h expected %h", pout8, 8'hA5); end
    bus_read(0, 2'd1, d);
    n_checks++; if (d !== 32'h0000_00A5) begin n_fail++; $display("FAIL rd_data_out: got %h expected %h", d, 32'hA5); end
    // read and write together: write lands, read returns the old value
    bus8.chipselect = 1; bus8.read = 1; bus8.write = 1; bus8.address = 2'd1; bus8.writedata = 32'h3C;
    tick(); idle();
    n_checks++; if (bus8.readdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL rw_prewrite: got %h expected %h", bus8.readdata, 32'hA5); end
    n_checks++; if (pout8 !== 8'h3C) begin n_fail++; $display("FAIL rw_write: got %h expected %h", pout8, 8'h3C); end
    bus_write(0, 2'd0, 32'hFF);
    bus_read(0, 2'd0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL wr_addr0_ignored: got %h expected %h", d, 32'h0); end
    // no side effects: readdata holds after the read strobe drops
    tick();
    n_checks++; if (bus8.readdata !== 32'h0) begin n_fail++; $display("FAIL rd_hold: got %h expected %h", bus8.readdata, 32'h0); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    bus_write(0, 2'd2, 32'h01);
    pin8 = 8'h01;
    tick();
    n_checks++; if (irq8 !== 1'b0) begin n_fail++; $display("FAIL edge_irq_n: got %b expected 0", irq8); end
    tick();
    n_checks++; if (irq8 !== 1'b0) begin n_fail++; $display("FAIL edge_irq_n1: got %b expected 0", irq8); end
    tick();
    n_checks++; if (irq8 !== 1'b1) begin n_fail++; $display("FAIL edge_irq_n2: got %b expected 1", irq8); end
    bus_read(0, 2'd3, d);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL edge_cap: got %h expected %h", d, 32'h01); end
    bus_read(0, 2'd0, d);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL edge_data_in: got %h expected %h", d, 32'h01); end
    bus_write(0, 2'd3, 32'h00);
    n_checks++; if (irq8 !== 1'b1) begin n_fail++; $display("FAIL edge_w0_noclear: got %b expected 1", irq8); end
    bus_write(0, 2'd3, 32'h01);
    n_checks++; if (irq8 !== 1'b0) begin n_fail++; $display("FAIL edge_clear_irq: got %b expected 0", irq8); end
    bus_read(0, 2'd3, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_cap_cleared: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_set_clear_collision();
    logic [31:0] d;
    pin8 = 8'h00; repeat (4) tick();
    pin8 = 8'h01; repeat (4) tick();
    pin8 = 8'h00; repeat (4) tick();
    bus_read(0, 2'd3, d);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL coll_preset: got %h expected %h", d, 32'h01); end
    pin8 = 8'h01;
    tick();
    tick();
    bus_write(0, 2'd3, 32'h01);
    n_checks++; if (irq8 !== 1'b1) begin n_fail++; $display("FAIL coll_irq: got %b expected 1", irq8); end
    bus_read(0, 2'd3, d);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL coll_cap: got %h expected %h", d, 32'h01); end
    bus_write(0, 2'd3, 32'h01);
    bus_read(0, 2'd3, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL coll_clear: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_reset_clears();
    logic [31:0] d;
    logic [7:0]  cap_after;
`ifdef PIO_DEBOUNCE_EN
    cap_after = 8'h0F;
`else
    cap_after = 8'h00;
`endif
    bus_write(0, 2'd1, 32'hFF);
    bus_write(0, 2'd2, 32'hFF);
    bus_write(0, 2'd3, 32'hFF);
    pin8 = 8'h00; repeat (12) tick();
    bus_write(0, 2'd3, 32'hFF);
    pin8 = 8'h0F; repeat (12) tick();
    bus_read(0, 2'd3, d);
    n_checks++; if (d !== 32'h0F) begin n_fail++; $display("FAIL rst_pre_cap: got %h expected %h", d, 32'h0F); end
    n_checks++; if (irq8 !== 1'b1) begin n_fail++; $display("FAIL rst_pre_irq: got %b expected 1", irq8); end
    // reset lands while a read is pending
    bus8.chipselect = 1; bus8.read = 1; bus8.address = 2'd1; rst = 1;
    tick(); idle();
    n_checks++; if (bus8.readdata !== 32'h0) begin n_fail++; $display("FAIL rst_abort_read: got %h expected %h", bus8.readdata, 32'h0); end
    n_checks++; if (pout8 !== 8'h00) begin n_fail++; $display("FAIL rst_pio_out: got %h expected %h", pout8, 8'h00); end
    n_checks++; if (irq8 !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b expected 0", irq8); end
    rst = 0;
    repeat (12) tick();
    bus_read(0, 2'd1, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_data_out: got %h expected %h", d, 32'h0); end
    bus_read(0, 2'd2, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_irq_mask: got %h expected %h", d, 32'h0); end
    bus_read(0, 2'd3, d);
    n_checks++; if (d !== {24'h0, cap_after}) begin n_fail++; $display("FAIL rst_edge_cap: got %h expected %h", d, {24'h0, cap_after}); end
    bus_read(0, 2'd0, d);
    n_checks++; if (d !== 32'h0F) begin n_fail++; $display("FAIL rst_data_in: got %h expected %h", d, 32'h0F); end
    n_checks++; if (irq8 !== 1'b0) begin n_fail++; $display("FAIL rst_irq_after: got %b expected 0", irq8); end
  endtask

  task automatic test_width5();
    logic [31:0] d;
    bus_write(1, 2'd1, 32'hFFFF_FFFF);
    n_checks++; if (pout5 !== 5'h1F) begin n_fail++; $display("FAIL w5_pio_out: got %h expected %h", pout5, 5'h1F); end
    bus_read(1, 2'd1, d);
    n_checks++; if (d !== 32'h0000_001F) begin n_fail++; $display("FAIL w5_readback: got %h expected %h", d, 32'h1F); end
    bus_write(1, 2'd2, 32'hFFFF_FFFF);
    bus_read(1, 2'd2, d);
    n_checks++; if (d !== 32'h0000_001F) begin n_fail++; $display("FAIL w5_mask: got %h expected %h", d, 32'h1F); end
    bus_write(1, 2'd3, 32'hFFFF_FFFF);
    pin5 = 5'h03; repeat (12) tick();
    bus_read(1, 2'd3, d);
    n_checks++; if (d !== 32'h03) begin n_fail++; $display("FAIL w5_any_rise: got %h expected %h", d, 32'h03); end
    n_checks++; if (irq5 !== 1'b1) begin n_fail++; $display("FAIL w5_irq: got %b expected 1", irq5); end
    bus_write(1, 2'd3, 32'hFFFF_FFFF);
    n_checks++; if (irq5 !== 1'b0) begin n_fail++; $display("FAIL w5_irq_clr: got %b expected 0", irq5); end
    pin5 = 5'h01; repeat (12) tick();
    bus_read(1, 2'd3, d);
    n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL w5_any_fall: got %h expected %h", d, 32'h02); end
  endtask

`ifndef PIO_DEBOUNCE_EN
  // Reference: hist[k] is the pin value present at clock edge k. A pin seen at edge k is
  // DATA_IN from edge k+1 on; a change between DATA_IN values is captured one edge later.
  task automatic test_random();
    logic [7:0]  hist [0:1023];
    logic [7:0]  m_out, m_mask, m_cap, p, din, rise;
    logic [31:0] m_rd, wd;
    logic [1:0]  a;
    bit          cs, rd, wr;
    int          n;
    rst = 1; pin8 = 0; idle(); tick();
    rst = 0; repeat (5) tick();
    m_out = 0; m_mask = 0; m_cap = 0; m_rd = 0; p = 0;
    for (int i = 0; i < 4; i++) hist[i] = 8'h00;
    n = 3;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) p = 8'($urandom);
      cs = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 2) == 0);
      a  = 2'($urandom);
      wd = $urandom;
      pin8 = p;
      bus8.chipselect = cs; bus8.read = rd; bus8.write = wr; bus8.address = a; bus8.writedata = wd;
      tick();
      n++;
      hist[n] = p;
      din  = hist[n-2];
      rise = hist[n-2] & ~hist[n-3];
      if (cs && rd) begin
        case (a)
          2'd0: m_rd = {24'h0, din};
          2'd1: m_rd = {24'h0, m_out};
          2'd2: m_rd = {24'h0, m_mask};
          default: m_rd = {24'h0, m_cap};
        endcase
      end
      if (cs && wr) begin
        case (a)
          2'd1: m_out = wd[7:0];
          2'd2: m_mask = wd[7:0];
          2'd3: m_cap = m_cap & ~wd[7:0];
          default: ;
        endcase
      end
      m_cap = m_cap | rise;
      n_checks++; if (bus8.readdata !== m_rd) begin n_fail++; $display("FAIL rnd_readdata cyc %0d: got %h expected %h", c, bus8.readdata, m_rd); end
      n_checks++; if (pout8 !== m_out) begin n_fail++; $display("FAIL rnd_pio_out cyc %0d: got %h expected %h", c, pout8, m_out); end
      n_checks++; if (irq8 !== |(m_cap & m_mask)) begin n_fail++; $display("FAIL rnd_irq cyc %0d: got %b expected %b", c, irq8, |(m_cap & m_mask)); end
    end
    idle();
  endtask
`endif

`ifdef PIO_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] d;
    rst = 1; pin8 = 0; idle(); tick();
    rst = 0; repeat (6) tick();
    pin8 = 8'h01; repeat (3) tick();
    pin8 = 8'h00; repeat (10) tick();
    bus_read(0, 2'd0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL deb_glitch_data_in: got %h expected %h", d, 32'h0); end
    bus_read(0, 2'd3, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL deb_glitch_cap: got %h expected %h", d, 32'h0); end
    pin8 = 8'h01; repeat (10) tick();
    bus_read(0, 2'd0, d);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL deb_stable_data_in: got %h expected %h", d, 32'h01); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
`ifndef PIO_DEBOUNCE_EN
    test_edge_irq();
    test_set_clear_collision();
`endif
    test_reset_clears();
    test_width5();
`ifndef PIO_DEBOUNCE_EN
    test_random();
`else
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
